// File: rtl/ps2_key_decoder_if.sv
// Bundles the PS/2 pin pair and the decoded key outputs into one connection.
// The master modport is the decoder itself. The slave modport is the board or bench side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    input  ps2_clk, ps2_data,
    output keycode, key_make, key_ext, key_valid, frame_err, busy, dbg_state
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  keycode, key_make, key_ext, key_valid, frame_err, busy, dbg_state
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host deframer with a scan-code set 2 prefix decoder (E0 extended, F0 break).
// The pins are synchronized and glitch-filtered. The frame FSM then steps on each filtered falling edge.
module ps2_key_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_decoder_if.master kbd
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic                   r_filt, r_fall, r_bit;
  logic [FW-1:0]          r_filt_cnt;
  state_t                 r_state, w_next;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [TW-1:0]          r_timer;
  logic                   r_ext_pend, r_brk_pend;
  logic [7:0]             r_keycode;
  logic                   r_key_make, r_key_ext, r_key_valid, r_frame_err;
  logic                   w_clk_s, w_data_s, w_timeout, w_stop_edge, w_good;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // The synchronizers reset to the idle-high line level so reset cannot fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], kbd.ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], kbd.ps2_data};
    end
  end

  // r_fall and r_bit are produced in the cycle the filtered clock flips low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
      r_bit      <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
        r_fall     <= r_filt;
        if (r_filt) r_bit <= w_data_s;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_timeout   = (r_state != S_IDLE) && !r_fall && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_stop_edge = r_fall && (r_state == S_STOP);
  assign w_good      = r_bit && (^{r_shift, r_par});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (r_fall) begin
      case (r_state)
        S_IDLE:   if (!r_bit) w_next = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_timer     <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_keycode   <= '0;
      r_key_make  <= 1'b0;
      r_key_ext   <= 1'b0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == S_IDLE || r_fall) r_timer <= '0;
      else                             r_timer <= r_timer + 1'b1;

      if (r_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {r_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          S_PARITY: r_par <= r_bit;
          default:  ;
        endcase
      end

      if (w_timeout || (w_stop_edge && !w_good)) begin
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_brk_pend  <= 1'b0;
      end else if (w_stop_edge) begin
        case (r_shift)
          8'hE0: r_ext_pend <= 1'b1;
          8'hF0: r_brk_pend <= 1'b1;
          8'hE1: ;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF: begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
          default: begin
            r_keycode   <= r_shift;
            r_key_ext   <= r_ext_pend;
            r_key_make  <= !r_brk_pend;
            r_key_valid <= 1'b1;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign kbd.keycode   = r_keycode;
  assign kbd.key_make  = r_key_make;
  assign kbd.key_ext   = r_key_ext;
  assign kbd.key_valid = r_key_valid;
  assign kbd.frame_err = r_frame_err;
  assign kbd.busy      = (r_state != S_IDLE);
  assign kbd.dbg_state = r_state;
endmodule
